// File: rtl/rs_chien_search.sv
// rtl/rs_chien_search.sv - RS(204,188) Chien search: scans sigma(x) roots one byte position per clock.
module rs_chien_search #(
  parameter int N = 204,
  parameter int T = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Sigma1,
  input  logic [7:0] Sigma2,
  input  logic [7:0] Sigma3,
  input  logic [7:0] Sigma4,
  input  logic [7:0] Sigma5,
  input  logic [7:0] Sigma6,
  input  logic [7:0] Sigma7,
  input  logic [7:0] Sigma8,
  output logic       Busy,
  output logic       Err_Valid,
  output logic [7:0] Err_Pos,
  output logic [7:0] Err_Loc,
  output logic       Done,
  output logic [3:0] Err_Count,
  output logic       Fail
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < e; i++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    return v;
  endfunction

  function automatic logic [8*T-1:0] pow_table(input int scale);
    logic [8*T-1:0] t;
    t = '0;
    for (int j = 0; j < T; j++) t[8*j +: 8] = gf_pow((scale * (j + 1)) % 255);
    return t;
  endfunction

  // r_j starts at Sigma_j * alpha^(-(N-1)*j) so the first cycle evaluates position N-1
  localparam int             INIT_SCALE = (255 - ((N - 1) % 255)) % 255;
  localparam logic [8*T-1:0] R_INIT     = pow_table(INIT_SCALE);
  localparam logic [8*T-1:0] R_STEP     = pow_table(1);
  localparam logic [7:0]     LOC_INIT   = gf_pow(N - 1);
  localparam logic [7:0]     ALPHA_INV  = gf_pow(254);

  state_t         state_q, state_d;
  logic [8*T-1:0] r_q, r_d;
  logic [7:0]     loc_q, loc_d;
  logic [7:0]     k_q, k_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     deg_q, deg_d;
  logic           busy_q, busy_d;
  logic           err_valid_q, err_valid_d;
  logic [7:0]     err_pos_q, err_pos_d;
  logic [7:0]     err_loc_q, err_loc_d;
  logic           done_q, done_d;
  logic [3:0]     err_count_q, err_count_d;
  logic           fail_q, fail_d;

  logic [8*T-1:0] sigma_in;
  logic [3:0]     sigma_deg;
  logic [7:0]     eval_s;

  assign sigma_in = {Sigma8, Sigma7, Sigma6, Sigma5, Sigma4, Sigma3, Sigma2, Sigma1};

  always_comb begin
    sigma_deg = 4'd0;
    for (int j = 0; j < T; j++) begin
      if (sigma_in[8*j +: 8] != 8'h00) sigma_deg = 4'(j + 1);
    end
  end

  always_comb begin
    eval_s = 8'h01;
    for (int j = 0; j < T; j++) eval_s = eval_s ^ r_q[8*j +: 8];
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    loc_d       = loc_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    deg_d       = deg_q;
    busy_d      = busy_q;
    err_valid_d = err_valid_q;
    err_pos_d   = err_pos_q;
    err_loc_d   = err_loc_q;
    done_d      = 1'b0;
    err_count_d = err_count_q;
    fail_d      = fail_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          for (int j = 0; j < T; j++) begin
            r_d[8*j +: 8] = gf_mul(sigma_in[8*j +: 8], R_INIT[8*j +: 8]);
          end
          loc_d       = LOC_INIT;
          deg_d       = sigma_deg;
          cnt_d       = 4'd0;
          k_d         = 8'd0;
          busy_d      = 1'b1;
          err_valid_d = 1'b0;
          err_count_d = 4'd0;
          fail_d      = 1'b0;
          state_d     = SCAN;
        end
      end

      SCAN: begin
        err_valid_d = (eval_s == 8'h00);
        if (eval_s == 8'h00) begin
          err_pos_d = k_q;
          err_loc_d = loc_q;
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        end
        for (int j = 0; j < T; j++) begin
          r_d[8*j +: 8] = gf_mul(r_q[8*j +: 8], R_STEP[8*j +: 8]);
        end
        loc_d = gf_mul(loc_q, ALPHA_INV);
        k_d   = k_q + 8'd1;
        if (k_q == 8'(N - 1)) state_d = FIN;
      end

      FIN: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        err_valid_d = 1'b0;
        err_count_d = cnt_q;
        // Roots beyond the shortened block are never visited, so they surface as cnt < deg
        fail_d      = (cnt_q != deg_q) || ((cnt_q == 4'd0) && (deg_q != 4'd0));
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      loc_q       <= 8'h00;
      k_q         <= 8'h00;
      cnt_q       <= 4'd0;
      deg_q       <= 4'd0;
      busy_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_pos_q   <= 8'h00;
      err_loc_q   <= 8'h00;
      done_q      <= 1'b0;
      err_count_q <= 4'd0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      loc_q       <= loc_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      deg_q       <= deg_d;
      busy_q      <= busy_d;
      err_valid_q <= err_valid_d;
      err_pos_q   <= err_pos_d;
      err_loc_q   <= err_loc_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      fail_q      <= fail_d;
    end
  end

  assign Busy      = busy_q;
  assign Err_Valid = err_valid_q;
  assign Err_Pos   = err_pos_q;
  assign Err_Loc   = err_loc_q;
  assign Done      = done_q;
  assign Err_Count = err_count_q;
  assign Fail      = fail_q;

endmodule

// File: tb/tb_rs_chien_search.sv
// tb/tb_rs_chien_search.sv - Self-checking bench for rs_chien_search (table vectors, random sigma, corner sequences).
module tb_rs_chien_search;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] Sigma1, Sigma2, Sigma3, Sigma4, Sigma5, Sigma6, Sigma7, Sigma8;
  logic       Busy;
  logic       Err_Valid;
  logic [7:0] Err_Pos;
  logic [7:0] Err_Loc;
  logic       Done;
  logic [3:0] Err_Count;
  logic       Fail;

  rs_chien_search dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Sigma1(Sigma1), .Sigma2(Sigma2), .Sigma3(Sigma3), .Sigma4(Sigma4),
    .Sigma5(Sigma5), .Sigma6(Sigma6), .Sigma7(Sigma7), .Sigma8(Sigma8),
    .Busy(Busy), .Err_Valid(Err_Valid), .Err_Pos(Err_Pos), .Err_Loc(Err_Loc),
    .Done(Done), .Err_Count(Err_Count), .Fail(Fail)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;

  int exp_t [0:254];
  int log_t [0:255];

  int exp_pos[$];
  int exp_loc[$];
  int exp_count;
  int exp_fail;
  int got_pos[$];
  int got_loc[$];

  typedef struct {
    logic [63:0] sig;
    int count;
    int fail;
    int nroots;
    int pos0;
    int loc0;
    int pos1;
    int loc1;
  } tvec_t;

  tvec_t tv[4];

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // sigma evaluated straight at x = alpha^-p
  function automatic int eval_at(input logic [63:0] sig, input int p);
    int v;
    v = 1;
    for (int j = 1; j <= 8; j++) begin
      v = v ^ gmul(int'(sig[8*(j-1) +: 8]), exp_t[((255 - (p % 255)) * j) % 255]);
    end
    return v;
  endfunction

  task automatic model(input logic [63:0] sig);
    int deg;
    exp_pos.delete();
    exp_loc.delete();
    for (int k = 0; k < 204; k++) begin
      if (eval_at(sig, 203 - k) == 0) begin
        exp_pos.push_back(k);
        exp_loc.push_back(exp_t[203 - k]);
      end
    end
    exp_count = (exp_pos.size() > 15) ? 15 : exp_pos.size();
    deg = 0;
    for (int j = 1; j <= 8; j++) if (sig[8*(j-1) +: 8] != 8'h00) deg = j;
    exp_fail = ((exp_count != deg) || (exp_count == 0 && deg != 0)) ? 1 : 0;
  endtask

  task automatic set_sigma(input logic [63:0] sig);
    Sigma1 = sig[7:0];   Sigma2 = sig[15:8];  Sigma3 = sig[23:16]; Sigma4 = sig[31:24];
    Sigma5 = sig[39:32]; Sigma6 = sig[47:40]; Sigma7 = sig[55:48]; Sigma8 = sig[63:56];
  endtask

  // mode 0: plain; 1: Start + new sigma at cycle 50; 2: Start during the FIN cycle
  task automatic run_scan(input logic [63:0] sig, input int mode);
    int c;
    int dcyc;
    model(sig);
    got_pos.delete();
    got_loc.delete();
    set_sigma(sig);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("busy_at_start", int'(Busy), 1);
    c = 0;
    dcyc = -1;
    while (c < 300 && dcyc < 0) begin
      if (mode == 1 && c == 49) begin
        Start = 1'b1;
        set_sigma({$urandom, $urandom});
      end
      if (mode == 1 && c == 50) Start = 1'b0;
      if (mode == 2 && c == 204) Start = 1'b1;
      @(posedge Clk); #1;
      c++;
      if (Err_Valid) begin
        got_pos.push_back(int'(Err_Pos));
        got_loc.push_back(int'(Err_Loc));
        chk("err_pos_timing", int'(Err_Pos), c - 1);
      end
      if (c == 1 || c == 204) chk("busy_during_scan", int'(Busy), 1);
      if (Done) dcyc = c;
    end
    Start = 1'b0;
    chk("done_cycle", dcyc, 205);
    chk("busy_at_done", int'(Busy), 0);
    chk("err_valid_at_done", int'(Err_Valid), 0);
    chk("err_count", int'(Err_Count), exp_count);
    chk("fail", int'(Fail), exp_fail);
    chk("n_roots", got_pos.size(), exp_pos.size());
    for (int i = 0; i < got_pos.size() && i < exp_pos.size(); i++) begin
      chk("root_pos", got_pos[i], exp_pos[i]);
      chk("root_loc", got_loc[i], exp_loc[i]);
    end
    @(posedge Clk); #1;
    chk("done_one_cycle", int'(Done), 0);
    chk("idle_after_done", int'(Busy), 0);
    chk("count_hold", int'(Err_Count), exp_count);
  endtask

  function automatic logic [63:0] sigma_from_roots(input int n, input bit outside);
    int poly [0:8];
    bit used [0:254];
    int p;
    logic [63:0] s;
    for (int i = 0; i <= 8; i++) poly[i] = 0;
    for (int i = 0; i < 255; i++) used[i] = 1'b0;
    poly[0] = 1;
    for (int r = 0; r < n; r++) begin
      do begin
        p = (outside && r == 0) ? $urandom_range(204, 254) : $urandom_range(0, 203);
      end while (used[p]);
      used[p] = 1'b1;
      for (int j = 8; j >= 1; j--) poly[j] = poly[j] ^ gmul(exp_t[p], poly[j-1]);
    end
    s = '0;
    for (int j = 1; j <= 8; j++) s[8*(j-1) +: 8] = 8'(poly[j]);
    return s;
  endfunction

  initial begin
    int x;
    int c;
    int done_seen;
    logic [63:0] sig;

    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x * 2;
      if (x >= 256) x = x ^ 'h11D;
    end
    log_t[0] = 0;

    tv[0] = '{64'h0, 0, 0, 0, 0, 0, 0, 0};
    tv[1] = '{{56'h0, 8'(exp_t[203])}, 1, 0, 1, 0, exp_t[203], 0, 0};
    tv[2] = '{64'h0000_0000_0000_0203, 2, 0, 2, 202, 2, 203, 1};
    tv[3] = '{{56'h0, 8'(exp_t[250])}, 0, 1, 0, 0, 0, 0, 0};

    Reset = 1'b0;
    Start = 1'b0;
    set_sigma(64'h0);
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_busy", int'(Busy), 0);
    chk("reset_err_valid", int'(Err_Valid), 0);
    chk("reset_done", int'(Done), 0);
    chk("reset_count", int'(Err_Count), 0);
    chk("reset_fail", int'(Fail), 0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_scan(tv[i].sig, 0);
      chk("tbl_count", int'(Err_Count), tv[i].count);
      chk("tbl_fail", int'(Fail), tv[i].fail);
      chk("tbl_nroots", got_pos.size(), tv[i].nroots);
      if (tv[i].nroots > 0 && got_pos.size() > 0) begin
        chk("tbl_pos0", got_pos[0], tv[i].pos0);
        chk("tbl_loc0", got_loc[0], tv[i].loc0);
      end
      if (tv[i].nroots > 1 && got_pos.size() > 1) begin
        chk("tbl_pos1", got_pos[1], tv[i].pos1);
        chk("tbl_loc1", got_loc[1], tv[i].loc1);
      end
    end

    run_scan(64'h0000_0000_0000_0203, 1);
    chk("midscan_n_roots", got_pos.size(), 2);
    run_scan(sigma_from_roots(3, 1'b0), 2);

    for (int it = 0; it < 18; it++) begin
      if (it % 6 == 5) sig = {$urandom, $urandom};
      else sig = sigma_from_roots($urandom_range(0, 8), ($urandom_range(0, 3) == 0));
      run_scan(sig, (it % 7 == 3) ? 1 : ((it % 7 == 6) ? 2 : 0));
    end

    // Reset at cycle 100: root at byte 10 leaves Err_Pos non-zero beforehand
    set_sigma({56'h0, 8'(exp_t[193])});
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (c = 1; c < 100; c++) begin
      if (c == 99) begin
        chk("pre_reset_pos", int'(Err_Pos), 10);
        Reset = 1'b0;
      end
      @(posedge Clk); #1;
    end
    chk("midreset_busy", int'(Busy), 0);
    chk("midreset_pos", int'(Err_Pos), 0);
    chk("midreset_loc", int'(Err_Loc), 0);
    chk("midreset_valid", int'(Err_Valid), 0);
    chk("midreset_done", int'(Done), 0);
    Reset = 1'b1;
    done_seen = 0;
    repeat (210) begin
      @(posedge Clk); #1;
      if (Done || Busy) done_seen = 1;
    end
    chk("no_done_after_reset", done_seen, 0);
    run_scan(64'h0000_0000_0000_0203, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rs_chien_search.md
Name: rs_chien_search

Overview:
- Chien search stage of the DVB-T RS(204,188) decoder. Sits directly downstream of the Berlekamp-Massey error-locator stage.
- Takes the eight error-locator coefficients Sigma1..Sigma8 (sigma0 = 1 implied) and evaluates sigma(x) at every codeword position of the shortened 204-byte block, one position per clock.
- Emits a strobe, a byte index and a locator value for each root found. These feed the Forney/correction stage.
- On completion, reports the error count and a decoding-failure flag.

Parameters:
- N, 204, shortened codeword length in bytes (positions p = N-1..0).
- T, 8, number of sigma coefficients / maximum correctable errors.

Ports:
- Clk  input  1  clock
- Reset  input  1  synchronous, active-low reset
- Start  input  1  one-cycle pulse: Sigma1..Sigma8 are valid, begin scan
- Sigma1..Sigma8  input  8 each  locator coefficients, GF(2^8) polynomial basis, field poly x^8+x^4+x^3+x^2+1
- Busy  output  1  scan in progress
- Err_Valid  output  1  current Err_Pos/Err_Loc identify an error byte
- Err_Pos  output  8  byte index in received order (0 = first byte = degree N-1)
- Err_Loc  output  8  locator X = alpha^p for that byte, polynomial basis
- Done  output  1  one-cycle pulse, scan complete
- Err_Count  output  4  number of roots found
- Fail  output  1  uncorrectable block

Behaviour:
- Reset (Reset=0 at posedge Clk):
  - All outputs go to 0; FSM goes to IDLE.
  - Applies mid-scan: the scan is abandoned, with no Done pulse.
- FSM states: IDLE, SCAN, FIN.
- IDLE:
  - On the edge E0 where Start=1, load r_j = Sigma_j * alpha^(52*j) for j=1..8, i.e. alpha^(-(N-1)*j) mod 255.
  - Also at E0: load loc = alpha^(N-1), compute deg = highest j with Sigma_j != 0 (0 if all zero), clear cnt and k.
  - Go to SCAN; Busy=1 from E0.
- SCAN, each cycle, for byte k (position p = N-1-k):
  - Evaluate s = 1 ^ r_1 ^ ... ^ r_8.
  - At the next edge, register the result: Err_Valid = (s==0), Err_Pos = k, Err_Loc = loc.
  - At the same edge, update r_j *= alpha^j (constant GF multipliers), loc *= alpha^-1, k++, and cnt++ if s==0 (saturating at 15).
  - Err_Pos/Err_Loc hold their last value when Err_Valid=0.
  - Timing: byte k's result is visible after edge E0+1+k.
  - After the edge registering k = N-1, go to FIN.
- FIN, one cycle:
  - At edge E0+N+1: Done=1, Busy=0, Err_Valid=0, Err_Count=cnt.
  - Fail = (cnt != deg) OR (cnt == 0 AND deg != 0).
  - Then return to IDLE. Done lasts exactly one cycle. Err_Count and Fail hold until the next Start.
- All-zero sigma: deg=0, no roots, Fail=0 (error-free block).
- Roots at positions 204..254 (outside the shortened code) are never scanned. They therefore yield cnt<deg, hence Fail=1.
- Start while Busy=1 is ignored. Start coincident with the FIN cycle is also ignored.
- Sigma inputs are sampled only at E0; they may change during the scan.
- GF multiply is combinational polynomial-basis multiply mod 0x11D. No lookup tables, no $readmem.
- Total latency Start→Done: N+1 cycles (205).
- Next Start is accepted one cycle after Done.

Test Plan:
- Reset, then Start with Sigma1..8=0 -> no Err_Valid; Done high exactly 205 cycles after Start edge; Err_Count=0, Fail=0; Busy high for cycles 1..204.
- Sigma1=alpha^203, rest 0 (error at byte 0) -> single Err_Valid one cycle after Start edge with Err_Pos=0, Err_Loc=alpha^203; Err_Count=1, Fail=0.
- Sigma1=0x03, Sigma2=0x02, rest 0 (roots p=0,1) -> Err_Valid on two consecutive cycles: Err_Pos=202 (Err_Loc=0x02), then Err_Pos=203 (Err_Loc=0x01); Err_Count=2, Fail=0.
- Sigma1=alpha^250, rest 0 (root outside shortened range) -> no Err_Valid; Done at 205; Err_Count=0, Fail=1.
- Start pulse at cycle 50 of an active scan, and Sigma inputs changed mid-scan -> no restart; results identical to the undisturbed run; Done at original time.
- Reset=0 at cycle 100 of a scan -> all outputs 0 next edge, no Done; subsequent Start runs a full correct scan.
